// File: rtl/gpio_port.sv
// gpio_port: PIC-style GPIO bank (LAT/TRIS/IOCEN/FLAG) on the SFR bus with interrupt-on-change.
// Optional GPIO_GLITCH_FILTER_EN adds a 3-sample stability filter ahead of PORT reads and change detect.
module gpio_port #(
    parameter int               WIDTH     = 13,
    parameter logic [WIDTH-1:0] RESET_LAT = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       io_addr,
    input  logic             io_wen,
    input  logic [7:0]       io_wdata,
    input  logic             io_ren,
    output logic [7:0]       io_rdata,
    output logic             io_rvalid,
    input  logic [WIDTH-1:0] io_pins_in,
    output logic [WIDTH-1:0] io_pins_out,
    output logic [WIDTH-1:0] io_pins_en,
    output logic             io_irq
);
    logic [WIDTH-1:0] lat, tris, iocen, flag, s1, s2, prev, pin_val, change, clr;
    logic [15:0]      rsel;

    // Replace one byte of a register; bits at or above WIDTH fall away in the cast.
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] cur, input logic hi, input logic [7:0] d);
        logic [15:0] e;
        e = 16'(cur);
        return hi ? WIDTH'({d, e[7:0]}) : WIDTH'({e[15:8], d});
    endfunction

`ifdef GPIO_GLITCH_FILTER_EN
    logic [WIDTH-1:0] h2, filt, stable;
    assign stable  = ~(s2 ^ prev) & ~(prev ^ h2);
    assign change  = stable & (s2 ^ filt);
    assign pin_val = filt;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h2   <= '0;
            filt <= '0;
        end else begin
            h2   <= prev;
            filt <= filt ^ change;
        end
    end
`else
    assign change  = s2 ^ prev;
    assign pin_val = s2;
`endif

    always_comb begin
        clr  = (io_wen && io_addr[2:1] == 2'd3) ? merge('0, io_addr[0], io_wdata) : '0;
        rsel = io_addr[2:1] == 2'd0 ? 16'(pin_val) :
               io_addr[2:1] == 2'd1 ? 16'(tris)    :
               io_addr[2:1] == 2'd2 ? 16'(iocen)   : 16'(flag);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat       <= RESET_LAT;
            tris      <= '1;
            iocen     <= '0;
            flag      <= '0;
            s1        <= '0;
            s2        <= '0;
            prev      <= '0;
            io_rdata  <= '0;
            io_rvalid <= 1'b0;
        end else begin
            s1        <= io_pins_in;
            s2        <= s1;
            prev      <= s2;
            flag      <= (flag & ~clr) | (change & iocen);
            io_rvalid <= io_ren;
            if (io_ren)
                io_rdata <= io_addr[0] ? rsel[15:8] : rsel[7:0];
            if (io_wen) begin
                case (io_addr[2:1])
                    2'd0:    lat   <= merge(lat, io_addr[0], io_wdata);
                    2'd1:    tris  <= merge(tris, io_addr[0], io_wdata);
                    2'd2:    iocen <= merge(iocen, io_addr[0], io_wdata);
                    default: ;
                endcase
            end
        end
    end

    assign io_pins_out = lat;
    assign io_pins_en  = ~tris;
    assign io_irq      = |(flag & iocen);
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: randomized and directed checks of gpio_port against a sample-history reference model.
module tb_gpio_port;
    localparam int          W    = 13;
    localparam logic [15:0] MASK = 16'h1FFF;
    localparam logic [12:0] RL   = 13'h0A5C;
`ifdef GPIO_GLITCH_FILTER_EN
    localparam int EXP_LAT = 5;
`else
    localparam int EXP_LAT = 3;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   io_addr;
    logic         io_wen;
    logic [7:0]   io_wdata;
    logic         io_ren;
    logic [7:0]   io_rdata;
    logic         io_rvalid;
    logic [W-1:0] io_pins_in;
    logic [W-1:0] io_pins_out;
    logic [W-1:0] io_pins_en;
    logic         io_irq;

    gpio_port #(.WIDTH(W), .RESET_LAT(RL)) dut (
        .clock(clock), .reset(reset), .io_addr(io_addr), .io_wen(io_wen), .io_wdata(io_wdata),
        .io_ren(io_ren), .io_rdata(io_rdata), .io_rvalid(io_rvalid), .io_pins_in(io_pins_in),
        .io_pins_out(io_pins_out), .io_pins_en(io_pins_en), .io_irq(io_irq)
    );

    always #5 clock = ~clock;

    logic [15:0] m_lat, m_tris, m_ioc, m_flag, mf;
    logic [15:0] ih [4];
    logic [7:0]  m_rdata;
    logic        m_rvalid;
    logic [15:0] pins;
    int          nvec = 0, nerr = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        m_lat = {3'b0, RL}; m_tris = MASK; m_ioc = '0; m_flag = '0; mf = '0;
        m_rdata = '0; m_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) ih[i] = '0;
    endtask

    // ih[k] is the pad value sampled k+1 edges before the edge being modelled.
    task automatic medge(input logic [2:0] a, input logic w, input logic [7:0] d, input logic r, input logic [15:0] p);
        logic [15:0] chg, pv, sel, wv, clr, keep, stable;
        int sh;
        sh = a[0] ? 8 : 0;
`ifdef GPIO_GLITCH_FILTER_EN
        stable = ~(ih[1] ^ ih[2]) & ~(ih[2] ^ ih[3]);
        chg = stable & (ih[1] ^ mf) & MASK;
        pv = mf;
        mf = mf ^ chg;
`else
        stable = '0;
        chg = ih[1] ^ ih[2];
        pv = ih[1];
`endif
        sel = a[2:1] == 2'd0 ? pv : a[2:1] == 2'd1 ? m_tris : a[2:1] == 2'd2 ? m_ioc : m_flag;
        if (r) m_rdata = 8'((sel >> sh) & 16'h00FF);
        m_rvalid = r;
        wv = 16'(d) << sh;
        keep = ~(16'h00FF << sh);
        clr = (w && a[2:1] == 2'd3) ? (wv & MASK) : 16'h0;
        m_flag = ((m_flag & ~clr) | (chg & m_ioc)) & MASK;
        if (w && a[2:1] == 2'd0) m_lat = ((m_lat & keep) | wv) & MASK;
        if (w && a[2:1] == 2'd1) m_tris = ((m_tris & keep) | wv) & MASK;
        if (w && a[2:1] == 2'd2) m_ioc = ((m_ioc & keep) | wv) & MASK;
        ih[3] = ih[2]; ih[2] = ih[1]; ih[1] = ih[0]; ih[0] = p & MASK;
    endtask

    task automatic cyc(input logic [2:0] a, input logic w, input logic [7:0] d, input logic r, input logic [15:0] p);
        io_addr = a; io_wen = w; io_wdata = d; io_ren = r; io_pins_in = p[W-1:0];
        @(posedge clock);
        medge(a, w, d, r, p);
        #1;
        check("pins_out", {3'b0, io_pins_out}, m_lat);
        check("pins_en", {3'b0, io_pins_en}, ~m_tris & MASK);
        check("irq", {15'b0, io_irq}, {15'b0, |(m_flag & m_ioc)});
        check("rvalid", {15'b0, io_rvalid}, {15'b0, m_rvalid});
        check("rdata", {8'b0, io_rdata}, {8'b0, m_rdata});
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_rvalid", {15'b0, io_rvalid}, 16'h0);
        check("rst_irq", {15'b0, io_irq}, 16'h0);
        check("rst_en", {3'b0, io_pins_en}, 16'h0);
        check("rst_out", {3'b0, io_pins_out}, {3'b0, RL});
        mreset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int lat;
        io_addr = '0; io_wen = 1'b0; io_wdata = '0; io_ren = 1'b0; io_pins_in = '0;
        pins = '0;
        @(negedge clock);
        do_reset();

        cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        cyc(3'd2, 1'b0, 8'h00, 1'b1, pins);
        check("tris_l", {8'b0, io_rdata}, 16'h00FF);
        cyc(3'd3, 1'b0, 8'h00, 1'b1, pins);
        check("tris_h", {8'b0, io_rdata}, 16'h001F);

        cyc(3'd2, 1'b1, 8'h00, 1'b0, pins);
        cyc(3'd0, 1'b1, 8'hA5, 1'b0, pins);
        check("drive_en", {8'b0, io_pins_en[7:0]}, 16'h00FF);
        check("drive_out", {8'b0, io_pins_out[7:0]}, 16'h00A5);
        pins = 16'h00A5;
        cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
`ifdef GPIO_GLITCH_FILTER_EN
        cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
`endif
        cyc(3'd0, 1'b0, 8'h00, 1'b1, pins);
        check("port_loop", {8'b0, io_rdata}, 16'h00A5);
        check("port_rvalid", {15'b0, io_rvalid}, 16'h1);
        cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        check("rvalid_1cyc", {15'b0, io_rvalid}, 16'h0);

        pins = '0;
        for (int i = 0; i < 6; i++) cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        cyc(3'd4, 1'b1, 8'h01, 1'b0, pins);
        pins = 16'h0001;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
            if (io_irq && lat == 0) lat = i;
        end
        check("ioc_latency", 16'(lat), 16'(EXP_LAT));
        cyc(3'd6, 1'b0, 8'h00, 1'b1, pins);
        check("flag_set", {8'b0, io_rdata}, 16'h0001);
        cyc(3'd6, 1'b1, 8'h01, 1'b0, pins);
        check("flag_clr", {15'b0, io_irq}, 16'h0);

        pins = '0;
        for (int i = 1; i < EXP_LAT; i++) cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        cyc(3'd6, 1'b1, 8'h01, 1'b0, pins);
        check("set_wins_irq", {15'b0, io_irq}, 16'h1);
        cyc(3'd6, 1'b0, 8'h00, 1'b1, pins);
        check("set_wins_flag", {8'b0, io_rdata}, 16'h0001);

        cyc(3'd4, 1'b1, 8'h00, 1'b0, pins);
        check("mask_irq", {15'b0, io_irq}, 16'h0);
        cyc(3'd6, 1'b0, 8'h00, 1'b1, pins);
        check("mask_flag", {8'b0, io_rdata}, 16'h0001);
        cyc(3'd4, 1'b1, 8'h01, 1'b0, pins);
        check("unmask_irq", {15'b0, io_irq}, 16'h1);

`ifdef GPIO_GLITCH_FILTER_EN
        cyc(3'd4, 1'b1, 8'h08, 1'b0, pins);
        pins = 16'h0008;
        for (int i = 0; i < 2; i++) cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        pins = '0;
        for (int i = 0; i < 8; i++) cyc(3'd0, 1'b0, 8'h00, 1'b1, pins);
        check("glitch_port", {8'b0, io_rdata & 8'h08}, 16'h0);
        check("glitch_irq", {15'b0, io_irq}, 16'h0);
        pins = 16'h0008;
        for (int i = 0; i < 4; i++) cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        pins = '0;
        for (int i = 0; i < 8; i++) cyc(3'd0, 1'b0, 8'h00, 1'b0, pins);
        cyc(3'd6, 1'b0, 8'h00, 1'b1, pins);
        check("pulse_flag", {8'b0, io_rdata & 8'h08}, 16'h0008);
`endif

        cyc(3'd2, 1'b0, 8'h00, 1'b1, pins);
        do_reset();
        cyc(3'd6, 1'b0, 8'h00, 1'b1, pins);
        check("reset_flag", {8'b0, io_rdata}, 16'h0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) pins = pins ^ (16'h1 << $urandom_range(0, W - 1));
            if (i == 700) do_reset();
            cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)), pins);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
